// File: rtl/interrupt_controller.sv
// Edge-triggered, masked, fixed-priority interrupt controller feeding the fetch unit.
// One request is presented at a time, and nothing new is requested until end-of-interrupt.
module interrupt_controller #(
    parameter int NUM_IRQ = 4,
    parameter int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               gie_set,
    input  logic               gie_clr,
    input  logic [NUM_IRQ-1:0] pend_clr,
    input  logic               int_ack,
    input  logic               int_eoi,
    output logic               int_req,
    output logic [ID_W-1:0]    int_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] mask,
    output logic               gie,
    output logic [NUM_IRQ-1:0] overrun
);

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t             state, state_nxt;
    logic [NUM_IRQ-1:0] irq_prev, edge_det, eligible, ack_clr, clr;
    logic [ID_W-1:0]    winner, int_id_nxt;
    logic               ack_ok;

    assign edge_det   = irq_in & ~irq_prev;
    assign eligible   = pending & ~mask;
    assign ack_ok     = (state == REQUEST) && int_ack;
    assign int_req    = (state == REQUEST);
    assign in_service = (state == SERVICE);

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            ack_clr[i] = ack_ok && (int_id == ID_W'(i));
    end

    assign clr = pend_clr | ack_clr;

    // Scan from the top so the lowest eligible index is the last assignment.
    always_comb begin
        winner = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (eligible[i]) winner = ID_W'(i);
    end

    always_comb begin
        state_nxt  = state;
        int_id_nxt = int_id;
        case (state)
            IDLE: begin
                if (gie && (|eligible)) begin
                    state_nxt  = REQUEST;
                    int_id_nxt = winner;
                end
            end
            REQUEST: begin
                if (int_ack)
                    state_nxt = SERVICE;
                else if (!gie || !eligible[int_id])
                    state_nxt = IDLE;
            end
            SERVICE: begin
                if (int_eoi) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            int_id   <= '0;
            pending  <= '0;
            overrun  <= '0;
            mask     <= '1;
            gie      <= 1'b0;
            irq_prev <= irq_in;
        end else begin
            state    <= state_nxt;
            int_id   <= int_id_nxt;
            irq_prev <= irq_in;
            // An edge beats a clear; a re-edge on a bit being cleared is not an overrun.
            pending  <= (pending & ~clr) | edge_det;
            overrun  <= overrun | (edge_det & pending & ~clr);
            if (mask_we) mask <= mask_wdata;
            if (gie_clr)      gie <= 1'b0;
            else if (gie_set) gie <= 1'b1;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed scenarios plus randomized traffic against a cycle-level behavioural model.
module tb_interrupt_controller;

    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  irq_in, mask_wdata, pend_clr;
    logic          mask_we, gie_set, gie_clr, int_ack, int_eoi;
    logic          int_req, in_service, gie;
    logic [IW-1:0] int_id;
    logic [N-1:0]  pending, mask, overrun;

    interrupt_controller #(.NUM_IRQ(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we),
        .mask_wdata(mask_wdata), .gie_set(gie_set), .gie_clr(gie_clr),
        .pend_clr(pend_clr), .int_ack(int_ack), .int_eoi(int_eoi),
        .int_req(int_req), .int_id(int_id), .in_service(in_service),
        .pending(pending), .mask(mask), .gie(gie), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: phase 0 = idle, 1 = requesting, 2 = handler running.
    int         m_phase;
    int         m_id;
    bit [N-1:0] m_pend, m_mask, m_ovr, m_prev;
    bit         m_gie;
    bit         m_valid = 0;

    always @(posedge clk) begin
        bit [N-1:0] np, no;
        bit         acc, rising, cleared;
        int         lowest;
        if (rst) begin
            m_phase = 0; m_id = 0; m_pend = '0; m_ovr = '0;
            m_mask = '1; m_gie = 0; m_prev = irq_in; m_valid = 1;
        end else if (m_valid) begin
            acc = (m_phase == 1) && int_ack;
            np = m_pend; no = m_ovr;
            lowest = -1;
            for (int i = 0; i < N; i++) begin
                rising  = irq_in[i] && !m_prev[i];
                cleared = pend_clr[i] || (acc && m_id == i);
                if (rising) begin
                    if (m_pend[i] && !cleared) no[i] = 1;
                    np[i] = 1;
                end else if (cleared) np[i] = 0;
            end
            for (int i = N - 1; i >= 0; i--)
                if (m_pend[i] && !m_mask[i]) lowest = i;
            if (m_phase == 0) begin
                if (m_gie && lowest >= 0) begin m_phase = 1; m_id = lowest; end
            end else if (m_phase == 1) begin
                if (int_ack) m_phase = 2;
                else if (!m_gie || !(m_pend[m_id] && !m_mask[m_id])) m_phase = 0;
            end else if (int_eoi) m_phase = 0;
            m_pend = np; m_ovr = no;
            if (mask_we) m_mask = mask_wdata;
            if (gie_clr) m_gie = 0;
            else if (gie_set) m_gie = 1;
            m_prev = irq_in;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            checks++;
            if (int_req !== (m_phase == 1) || in_service !== (m_phase == 2) ||
                int_id !== IW'(m_id) || pending !== m_pend || mask !== m_mask ||
                gie !== m_gie || overrun !== m_ovr) begin
                failures++;
                $display("FAIL model t=%0t req=%b/%b svc=%b/%b id=%0d/%0d pend=%b/%b mask=%b/%b gie=%b/%b ovr=%b/%b",
                    $time, int_req, m_phase == 1, in_service, m_phase == 2, int_id, m_id,
                    pending, m_pend, mask, m_mask, gie, m_gie, overrun, m_ovr);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_strobes();
        mask_we = 0; gie_set = 0; gie_clr = 0; pend_clr = '0; int_ack = 0; int_eoi = 0;
    endtask

    initial begin
        rst = 1; irq_in = 4'b0010; mask_wdata = '0;
        clear_strobes();
        tick(2);
        rst = 0;
        tick();
        // Line high through reset is not an event.
        mask_we = 1; mask_wdata = '0; gie_set = 1;
        tick();
        clear_strobes();
        tick(3);
        chk("held_line_pending", int'(pending), 0);
        chk("held_line_noreq", int'(int_req), 0);

        // Single source round trip.
        irq_in = 4'b0110; tick();
        chk("pend2_after_k", int'(pending), 4);
        chk("noreq_after_k", int'(int_req), 0);
        irq_in = 4'b0010; tick();
        chk("req_after_k1", int'(int_req), 1);
        chk("id2", int'(int_id), 2);
        int_ack = 1; tick(); int_ack = 0;
        chk("svc_after_ack", int'(in_service), 1);
        chk("pend2_cleared", int'(pending[2]), 0);
        chk("req_low_in_svc", int'(int_req), 0);
        tick(2);
        int_eoi = 1; tick(); int_eoi = 0;
        chk("idle_after_eoi", int'(in_service), 0);

        // Priority: sources 3 and 1 together.
        irq_in = 4'b0000; tick();
        irq_in = 4'b1010; tick(2);
        chk("prio_first_id1", int'(int_id), 1);
        chk("prio_first_req", int'(int_req), 1);
        int_ack = 1; tick(); int_ack = 0;
        int_eoi = 1; tick(); int_eoi = 0;
        tick();
        chk("prio_second_id3", int'(int_id), 3);
        chk("prio_second_req", int'(int_req), 1);
        int_ack = 1; tick(); int_ack = 0;
        int_eoi = 1; tick(); int_eoi = 0;
        irq_in = 4'b0000; tick();

        // Mask withdraws a pending request, unmask re-requests.
        irq_in = 4'b0100; tick(); irq_in = 4'b0000; tick();
        chk("mask_req_id2", int'(int_id), 2);
        mask_we = 1; mask_wdata = 4'b0100; tick(); mask_we = 0; tick();
        chk("withdraw_req", int'(int_req), 0);
        chk("withdraw_keeps_pend", int'(pending[2]), 1);
        mask_we = 1; mask_wdata = 4'b0000; tick(); mask_we = 0; tick();
        chk("rereq", int'(int_req), 1);
        chk("rereq_id2", int'(int_id), 2);
        int_ack = 1; tick(); int_ack = 0;
        int_eoi = 1; tick(); int_eoi = 0;

        // Overrun while servicing source 0.
        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick();
        chk("req_id0", int'(int_id), 0);
        int_ack = 1; tick(); int_ack = 0;
        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick();
        irq_in = 4'b0001; tick(); irq_in = 4'b0000; tick();
        chk("svc_pend0", int'(pending[0]), 1);
        chk("svc_ovr0", int'(overrun[0]), 1);
        chk("svc_noreq", int'(int_req), 0);
        int_eoi = 1; tick(); int_eoi = 0; tick();
        chk("after_eoi_req0", int'(int_req), 1);
        chk("after_eoi_id0", int'(int_id), 0);
        int_ack = 1; tick(); int_ack = 0;
        int_eoi = 1; tick(); int_eoi = 0;

        // Spurious handshakes, then reset mid-service.
        int_ack = 1; tick(); int_ack = 0;
        chk("spur_ack_idle", int'({int_req, in_service}), 0);
        irq_in = 4'b1000; tick(); irq_in = 4'b0000; tick();
        int_eoi = 1; tick(); int_eoi = 0;
        chk("spur_eoi_req", int'(int_req), 1);
        chk("spur_eoi_id3", int'(int_id), 3);
        int_ack = 1; tick(); int_ack = 0;
        chk("svc_before_rst", int'(in_service), 1);
        rst = 1; tick(); rst = 0;
        chk("rst_req_svc", int'({int_req, in_service}), 0);
        chk("rst_pend", int'(pending), 0);
        chk("rst_ovr", int'(overrun), 0);
        chk("rst_mask", int'(mask), 15);
        chk("rst_gie", int'(gie), 0);
        chk("rst_id", int'(int_id), 0);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            irq_in     = N'($urandom);
            mask_we    = ($urandom_range(7) == 0);
            mask_wdata = N'($urandom) & N'($urandom);
            gie_set    = ($urandom_range(3) == 0);
            gie_clr    = ($urandom_range(9) == 0);
            for (int i = 0; i < N; i++) pend_clr[i] = ($urandom_range(9) == 0);
            int_ack    = ($urandom_range(2) == 0);
            int_eoi    = ($urandom_range(3) == 0);
            rst        = ($urandom_range(299) == 0);
            tick();
        end
        rst = 0;
        clear_strobes();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
